// File: rtl/cmd_frame_sender_if.sv
// Byte stream from the command framer to the UART transmitter user port.
// A byte moves on every clock where tx_valid and tx_ready are both high.
interface cmd_frame_sender_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/cmd_frame_sender.sv
// Host-side command framer: packs the stored payload into
// head, type, length, payload[, checksum] and streams it to the UART.
//
// state   | meaning
// --------+--------------------------------------------------------
// S_IDLE  | waiting for i_start, payload buffer open for writes
// S_HEAD  | presenting the head byte
// S_TYPE  | presenting the latched type byte
// S_LEN   | presenting the latched length byte
// S_DATA  | presenting payload byte idx_q
// S_CSUM  | presenting the checksum byte
// S_GAP   | quiet time before o_done, gap_q counts down to zero
module cmd_frame_sender #(
  parameter logic [7:0] P_HEAD       = 8'h55,
  parameter int         P_MAX_LEN    = 16,
  parameter bit         P_CHECK_EN   = 1'b0,
  parameter int         P_GAP_CYCLES = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [7:0]                     i_pl_data,
  input  logic                           i_pl_wr,
  output logic                           o_pl_ready,
  output logic [$clog2(P_MAX_LEN+1)-1:0] o_pl_count,
  input  logic                           i_start,
  input  logic [7:0]                     i_type,
  input  logic [7:0]                     i_len,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_err,
  cmd_frame_sender_if.master             tx
);

  localparam int CW = $clog2(P_MAX_LEN + 1);
  localparam int IW = (P_MAX_LEN > 1) ? $clog2(P_MAX_LEN) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(P_MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_HEAD, S_TYPE, S_LEN, S_DATA, S_CSUM, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    type_q, type_d;
  logic [7:0]    len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [15:0]   gap_q, gap_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [7:0]    mem_q [P_MAX_LEN];
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] idx_nxt;
  logic          fire, len_ok, start_acc;
  logic          payload_end, tail_start, frame_end;

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign o_pl_count  = count_q;
  assign o_pl_ready  = !busy_q && (count_q < MAX_CNT);
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    type_d      = type_q;
    len_d       = len_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    gap_d       = gap_q;
    count_d     = count_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    payload_end = 1'b0;
    tail_start  = 1'b0;
    frame_end   = 1'b0;
    fire        = tx_valid_q && tx.tx_ready;
    idx_nxt     = idx_q + 1'b1;
    len_ok      = (i_len <= 8'(count_q)) && ({1'b0, i_len} <= 9'(P_MAX_LEN));
    start_acc   = (state_q == S_IDLE) && i_start && len_ok;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (len_ok) begin
            state_d    = S_HEAD;
            tx_valid_d = 1'b1;
            tx_data_d  = P_HEAD;
            type_d     = i_type;
            len_d      = i_len;
            csum_d     = i_type + i_len;
            idx_d      = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_HEAD: if (fire) begin
        state_d   = S_TYPE;
        tx_data_d = type_q;
      end
      S_TYPE: if (fire) begin
        state_d   = S_LEN;
        tx_data_d = len_q;
      end
      S_LEN: if (fire) begin
        if (len_q != 8'd0) begin
          state_d   = S_DATA;
          idx_d     = '0;
          tx_data_d = mem_q[0];
        end else begin
          payload_end = 1'b1;
        end
      end
      S_DATA: if (fire) begin
        csum_d = csum_q + tx_data_q;
        if (8'(idx_q) == len_q - 8'd1) begin
          payload_end = 1'b1;
        end else begin
          idx_d     = idx_nxt;
          tx_data_d = mem_q[idx_nxt];
        end
      end
      S_CSUM: if (fire) tail_start = 1'b1;
      S_GAP: begin
        if (gap_q == 16'd0) frame_end = 1'b1;
        else gap_d = gap_q - 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // csum_d already includes the last payload byte here
    if (payload_end) begin
      if (P_CHECK_EN) begin
        state_d   = S_CSUM;
        tx_data_d = csum_d;
      end else begin
        tail_start = 1'b1;
      end
    end

    if (tail_start) begin
      tx_valid_d = 1'b0;
      tx_data_d  = 8'd0;
      if (P_GAP_CYCLES != 0) begin
        state_d = S_GAP;
        gap_d   = 16'(P_GAP_CYCLES - 1);
      end else begin
        frame_end = 1'b1;
      end
    end

    // the whole buffer is released once the frame is out, unused bytes too
    if (frame_end) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
      count_d = '0;
    end

    wr_en  = i_pl_wr && o_pl_ready && !start_acc;
    wr_idx = IW'(count_q);
    if (wr_en) count_d = count_q + 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      type_q     <= 8'd0;
      len_q      <= 8'd0;
      idx_q      <= '0;
      csum_q     <= 8'd0;
      gap_q      <= 16'd0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      type_q     <= type_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      gap_q      <= gap_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // payload storage needs no reset: count_q defines which bytes are valid
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_idx] <= i_pl_data;
  end

endmodule
